// File: rtl/uart_dram_loader_if.sv
// uart_dram_loader_if: DRAM write bus driven by the serial boot loader.
interface uart_dram_loader_if;
   logic [15:0] dram_address;
   logic [7:0]  dram_data;
   logic        dram_wren;
   modport master (output dram_address, output dram_data, output dram_wren);
   modport slave  (input dram_address, input dram_data, input dram_wren);
endinterface

// File: rtl/uart_dram_loader.sv
// uart_dram_loader: receives 8N1 UART bytes and writes them to DRAM from address 0,
// raising sticky rx_done once IMAGE_BYTES bytes have been stored.
module uart_dram_loader #(
   parameter int CLKS_PER_BIT = 434,
   parameter int IMAGE_BYTES  = 65536
) (
   input  logic                 clk_in,
   input  logic                 rst_n,
   input  logic                 rx,
   uart_dram_loader_if.master   bus,
   output logic                 rx_done,
   output logic                 frame_error
);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [16:0]   LAST   = 17'(IMAGE_BYTES - 1);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;
   logic [1:0]    r_sync;
   logic [2:0]    r_state;
   logic [TW-1:0] r_timer;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic [16:0]   r_count;
   logic [15:0]   r_addr;
   logic [7:0]    r_data;
   logic          r_wren;
   logic          r_done;
   logic          r_fe;
   logic          w_rx_s;
   logic          w_full;
   logic          w_half;
   assign w_rx_s = r_sync[1];
   assign w_full = r_timer == T_FULL;
   assign w_half = r_timer == T_HALF;
   // Count is one bit wider than the address so a full 64 KiB image terminates at 0xFFFF.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_sync  <= 2'b11;
         r_state <= S_IDLE;
         r_timer <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_count <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_wren  <= 1'b0;
         r_done  <= 1'b0;
         r_fe    <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], rx};
         r_wren <= 1'b0;
         r_fe   <= 1'b0;
         case (r_state)
            S_IDLE: if (!w_rx_s) begin
               r_state <= S_START;
               r_timer <= '0;
            end
            S_START: if (w_half) begin
               r_state <= w_rx_s ? S_IDLE : S_DATA;
               r_timer <= '0;
               r_bit   <= '0;
            end else r_timer <= r_timer + TW'(1);
            S_DATA: if (w_full) begin
               r_timer <= '0;
               r_shift <= {w_rx_s, r_shift[7:1]};
               r_bit   <= r_bit + 3'd1;
               if (r_bit == 3'd7) r_state <= S_STOP;
            end else r_timer <= r_timer + TW'(1);
            S_STOP: if (w_full) begin
               r_timer <= '0;
               if (w_rx_s) begin
                  r_state <= S_WRITE;
                  r_wren  <= 1'b1;
                  r_addr  <= r_count[15:0];
                  r_data  <= r_shift;
               end else begin
                  r_state <= S_IDLE;
                  r_fe    <= 1'b1;
               end
            end else r_timer <= r_timer + TW'(1);
            S_WRITE: begin
               r_count <= r_count + 17'd1;
               r_state <= (r_count == LAST) ? S_DONE : S_IDLE;
               r_done  <= r_count == LAST;
            end
            S_DONE: r_state <= S_DONE;
            default: r_state <= S_IDLE;
         endcase
      end
   end
   assign bus.dram_address = r_addr;
   assign bus.dram_data    = r_data;
   assign bus.dram_wren    = r_wren;
   assign rx_done          = r_done;
   assign frame_error      = r_fe;
endmodule
